// File: rtl/mux2_rr_arbiter.sv
// Two-input round-robin arbiter feeding a single registered output stage and the 2:1 mux select.
// Define MUX2_ARB_LOCK_EN to hold the grant on one input until its packet's last beat.
module mux2_rr_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i0_valid,
  input  logic [DATA_W-1:0] i0_data,
  input  logic              i0_last,
  output logic              i0_ready,
  input  logic              i1_valid,
  input  logic [DATA_W-1:0] i1_data,
  input  logic              i1_last,
  output logic              i1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              s
);

  logic              load;
  logic              req0, req1;
  logic              gnt0, gnt1;
  logic              ptr_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              s_q;

`ifdef MUX2_ARB_LOCK_EN
  typedef enum logic [1:0] {StArb, StLock0, StLock1} state_e;
  state_e state_q, state_d;

  // A locked state masks the other input entirely, so the owner wins as a lone requester.
  assign req0 = i0_valid && (state_q != StLock1);
  assign req1 = i1_valid && (state_q != StLock0);

  always_comb begin
    state_d = state_q;
    if (gnt0) begin
      state_d = i0_last ? StArb : StLock0;
    end else if (gnt1) begin
      state_d = i1_last ? StArb : StLock1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StArb;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign req0 = i0_valid;
  assign req1 = i1_valid;
`endif

  assign load = !out_valid_q || out_ready;

  // ptr holds the last granted input; the other one wins a tie.
  always_comb begin
    gnt0 = load && req0 && (!req1 || ptr_q);
    gnt1 = load && req1 && (!req0 || !ptr_q);
  end

  assign i0_ready = gnt0 && !rst;
  assign i1_ready = gnt1 && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      s_q         <= 1'b0;
      ptr_q       <= 1'b1;
    end else if (load) begin
      if (gnt0) begin
        out_valid_q <= 1'b1;
        out_data_q  <= i0_data;
        out_last_q  <= i0_last;
        s_q         <= 1'b0;
        ptr_q       <= 1'b0;
      end else if (gnt1) begin
        out_valid_q <= 1'b1;
        out_data_q  <= i1_data;
        out_last_q  <= i1_last;
        s_q         <= 1'b1;
        ptr_q       <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign s         = s_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model of the arbitration rules.
module tb_mux2_rr_arbiter;

`ifdef MUX2_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i0_valid = 1'b0, i1_valid = 1'b0;
  logic [7:0] i0_data = 8'h00, i1_data = 8'h00;
  logic       i0_last = 1'b0, i1_last = 1'b0;
  logic       i0_ready, i1_ready;
  logic       out_valid, out_last, out_ready = 1'b0, s;
  logic [7:0] out_data;

  int total = 0;
  int bad = 0;

  mux2_rr_arbiter #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .i0_valid (i0_valid),
    .i0_data  (i0_data),
    .i0_last  (i0_last),
    .i0_ready (i0_ready),
    .i1_valid (i1_valid),
    .i1_data  (i1_data),
    .i1_last  (i1_last),
    .i1_ready (i1_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .s        (s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who is "owed" the next contended grant, who holds a packet lock,
  // and what the output register must contain.
  bit       m_valid = 1'b0;
  bit [7:0] m_data = 8'h00;
  bit       m_last = 1'b0;
  bit       m_s = 1'b0;
  int       m_last_winner = 1;
  int       m_lock_owner = -1;
  bit       chk_en = 1'b0;

  function automatic bit [1:0] model_gnt();
    bit can_take, want0, want1;
    can_take = !m_valid || out_ready;
    want0 = i0_valid && (m_lock_owner != 1);
    want1 = i1_valid && (m_lock_owner != 0);
    if (rst || !can_take) return 2'b00;
    if (want0 && want1) return (m_last_winner == 0) ? 2'b10 : 2'b01;
    return {want1, want0};
  endfunction

  always @(posedge clk) begin
    bit [1:0] g;
    g = model_gnt();
    chk_en <= 1'b1;
    if (rst) begin
      m_valid <= 1'b0; m_data <= 8'h00; m_last <= 1'b0; m_s <= 1'b0;
      m_last_winner <= 1; m_lock_owner <= -1;
    end else if (g[0]) begin
      m_valid <= 1'b1; m_data <= i0_data; m_last <= i0_last; m_s <= 1'b0;
      m_last_winner <= 0;
      if (LockEn) m_lock_owner <= i0_last ? -1 : 0;
    end else if (g[1]) begin
      m_valid <= 1'b1; m_data <= i1_data; m_last <= i1_last; m_s <= 1'b1;
      m_last_winner <= 1;
      if (LockEn) m_lock_owner <= i1_last ? -1 : 1;
    end else if (!m_valid || out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    bit [1:0] g;
    if (chk_en) begin
      g = model_gnt();
      check("cmp_i0_ready", {31'd0, i0_ready}, {31'd0, g[0]});
      check("cmp_i1_ready", {31'd0, i1_ready}, {31'd0, g[1]});
      check("cmp_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("cmp_out_data", {24'd0, out_data}, {24'd0, m_data});
      check("cmp_out_last", {31'd0, out_last}, {31'd0, m_last});
      check("cmp_s", {31'd0, s}, {31'd0, m_s});
    end
  end

  // Handshake observers for the directed packet test.
  bit       acc0 = 1'b0;
  bit [7:0] out_log[$];
  always @(posedge clk) begin
    acc0 <= i0_valid && i0_ready && !rst;
    if (out_valid && out_ready && !rst) out_log.push_back(out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i0_valid = 1'b0; i1_valid = 1'b0; i0_last = 1'b0; i1_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit [7:0] pkt[3];
    int idx;
    bit [7:0] exp_seq[4];

    // 1. Reset with both inputs valid
    i0_valid = 1'b1; i1_valid = 1'b1; i0_data = 8'h12; i1_data = 8'h34; out_ready = 1'b1;
    step();
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", {31'd0, s}, 32'd0);
    check("rst_i0_ready", {31'd0, i0_ready}, 32'd0);
    check("rst_i1_ready", {31'd0, i1_ready}, 32'd0);
    step();
    idle_inputs();
    rst = 1'b0;

    // 2. Single stream back to back
    do_reset();
    out_ready = 1'b1;
    i0_valid = 1'b1; i0_data = 8'h11;
    @(negedge clk);
    check("single_i0_ready", {31'd0, i0_ready}, 32'd1);
    step(); i0_data = 8'h22;
    @(negedge clk);
    check("single_beat1", {24'd0, out_data}, 32'h11);
    check("single_s", {31'd0, s}, 32'd0);
    step(); i0_data = 8'h33;
    @(negedge clk);
    check("single_beat2", {24'd0, out_data}, 32'h22);
    step(); i0_valid = 1'b0;
    @(negedge clk);
    check("single_beat3", {24'd0, out_data}, 32'h33);
    check("single_valid3", {31'd0, out_valid}, 32'd1);
    step();
    @(negedge clk);
    check("single_drain", {31'd0, out_valid}, 32'd0);

    // 3. Continuous contention alternates strictly, i0 first
    do_reset();
    i0_valid = 1'b1; i1_valid = 1'b1; i0_data = 8'hA0; i1_data = 8'hB0;
    i0_last = 1'b1; i1_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check("cont_data", {24'd0, out_data}, (k % 2 == 0) ? 32'hA0 : 32'hB0);
      check("cont_s", {31'd0, s}, (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    idle_inputs();

    // 4. Backpressure holds 0x55; release grants the owed input in the same cycle
    do_reset();
    out_ready = 1'b0;
    i0_valid = 1'b1; i0_data = 8'h55; i0_last = 1'b1;
    step();
    i0_data = 8'h66; i1_valid = 1'b1; i1_data = 8'h77; i1_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_data", {24'd0, out_data}, 32'h55);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_ready", {30'd0, i1_ready, i0_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_i1_ready", {31'd0, i1_ready}, 32'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("bp_next_beat", {24'd0, out_data}, 32'h77);

    // 5. Three-beat packet on i0 while i1 keeps requesting
    do_reset();
    out_log.delete();
    pkt[0] = 8'hA1; pkt[1] = 8'hA2; pkt[2] = 8'hA3;
    idx = 0;
    i1_valid = 1'b1; i1_data = 8'hB1; i1_last = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (acc0) idx++;
      i0_valid = (idx < 3);
      i0_data  = (idx < 3) ? pkt[idx] : 8'h00;
      i0_last  = (idx == 2);
      step();
    end
    idle_inputs();
    if (LockEn) begin
      exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3; exp_seq[3] = 8'hB1;
    end else begin
      exp_seq[0] = 8'hA1; exp_seq[1] = 8'hB1; exp_seq[2] = 8'hA2; exp_seq[3] = 8'hB1;
    end
    check("pkt_count_ge4", {31'd0, out_log.size() >= 4}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("pkt_order", {24'd0, (k < out_log.size()) ? out_log[k] : 8'hxx}, {24'd0, exp_seq[k]});
    end

    // 6. Reset while the output stage is stalled
    do_reset();
    out_ready = 1'b0;
    i0_valid = 1'b1; i0_data = 8'h3C; i0_last = 1'b0;
    step();
    @(negedge clk);
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    step();
    rst = 1'b1; i1_valid = 1'b1; i1_data = 8'h4D;
    @(negedge clk);
    check("mid_rst_ready", {30'd0, i1_ready, i0_ready}, 32'd0);
    step();
    rst = 1'b0; out_ready = 1'b1; i0_last = 1'b1; i1_last = 1'b1;
    @(negedge clk);
    check("mid_post_valid", {31'd0, out_valid}, 32'd0);
    check("mid_first_i0", {30'd0, i1_ready, i0_ready}, 32'd1);
    step();
    idle_inputs();

    // Randomized traffic, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 99) == 0);
      i0_valid  = $urandom_range(0, 3) != 0;
      i1_valid  = $urandom_range(0, 3) != 0;
      i0_data   = 8'($urandom_range(0, 255));
      i1_data   = 8'($urandom_range(0, 255));
      i0_last   = $urandom_range(0, 2) == 0;
      i1_last   = $urandom_range(0, 2) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
